// File: rtl/ecc_secded_pkg.sv
// Shared types and constant functions for the SECDED link: parity sizing and
// the mapping of payload bits onto Hamming codeword positions.
package ecc_secded_pkg;

  typedef enum logic [1:0] {
    CLEAN  = 2'd0,
    CORR   = 2'd1,
    UNCORR = 2'd2
  } syn_class_e;

  // Smallest p with 2^p >= data_w + p + 1.
  function automatic int calc_par_w(input int data_w);
    int p;
    p = 0;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  function automatic bit is_pow2(input int idx);
    return (idx > 0) && ((idx & (idx - 1)) == 0);
  endfunction

  // Codeword position carrying payload bit idx (data fills non-power-of-2 slots).
  function automatic int data_pos(input int data_w, input int idx);
    int n;
    int pos_out;
    n       = 0;
    pos_out = 0;
    for (int pos = 1; pos <= data_w + calc_par_w(data_w); pos++) begin
      if (!is_pow2(pos)) begin
        if (n == idx) pos_out = pos;
        n++;
      end
    end
    return pos_out;
  endfunction

  // Payload bit index held at codeword position pos, or -1 for parity slots.
  function automatic int pos_data_idx(input int pos);
    int n;
    n = 0;
    if (is_pow2(pos) || pos == 0) return -1;
    for (int p = 1; p < pos; p++) begin
      if (!is_pow2(p)) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/ecc_secded_dec.sv
// Combinational SECDED decoder: syndrome, overall parity, single-bit repair
// and payload extraction for one codeword.
module ecc_secded_dec
  import ecc_secded_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int CW_W   = DATA_W + PAR_W + 1
) (
  input  logic [CW_W-1:0]   i_cw,
  output logic [DATA_W-1:0] o_data,
  output logic [PAR_W-1:0]  o_syn,
  output logic              o_corrected,
  output logic              o_uncorrectable
);

  logic [PAR_W-1:0] w_syn;
  logic             w_pe;
  logic [CW_W-1:0]  w_fix;
  syn_class_e       w_cls;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_syn = '0;
    for (int pos = 1; pos < CW_W; pos++) begin
      if (i_cw[pos]) w_syn = w_syn ^ PAR_W'(pos);
    end
  end

  assign w_pe = ^i_cw;

  // A nonzero syndrome with odd parity is only repairable if it names a real position.
  always_comb begin
    w_fix = i_cw;
    w_cls = CLEAN;
    if (w_syn == '0) begin
      w_cls = w_pe ? CORR : CLEAN;
    end else if (w_pe && (int'(w_syn) <= CW_W - 1)) begin
      w_fix = i_cw ^ (CW_W'(1) << w_syn);
      w_cls = CORR;
    end else begin
      w_cls = UNCORR;
    end
  end

  always_comb begin
    o_data = '0;
    for (int i = 0; i < DATA_W; i++) o_data[i] = w_fix[data_pos(DATA_W, i)];
  end

  assign o_syn           = w_syn;
  assign o_corrected     = (w_cls == CORR);
  assign o_uncorrectable = (w_cls == UNCORR);

endmodule

// File: rtl/ecc_secded_link.sv
// Two-stage SECDED loopback link: S1 encodes and injects errors, S2 decodes;
// valid/ready handshake with saturating corrected/uncorrectable counters.
module ecc_secded_link
  import ecc_secded_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int CNT_W  = 16,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int CW_W   = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CW_W-1:0]   inject_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corrected,
  output logic              out_uncorrectable,
  output logic [PAR_W-1:0]  out_syndrome,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic              r_s1_valid;
  logic [CW_W-1:0]   r_s1_cw;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_data;
  logic              r_s2_corr;
  logic              r_s2_uncorr;
  logic [PAR_W-1:0]  r_s2_syn;
  logic [CNT_W-1:0]  r_corr_cnt;
  logic [CNT_W-1:0]  r_uncorr_cnt;

  logic              w_s1_adv;
  logic              w_s2_adv;
  logic              w_fire;
  logic [CW_W-1:0]   w_enc;
  logic [DATA_W-1:0] w_dec_data;
  logic [PAR_W-1:0]  w_dec_syn;
  logic              w_dec_corr;
  logic              w_dec_uncorr;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_fire   = r_s2_valid && out_ready;

  // Parity k covers data positions with index bit k set; parity slots are still zero here.
  always_comb begin
    w_enc = '0;
    for (int i = 0; i < DATA_W; i++) w_enc[data_pos(DATA_W, i)] = in_data[i];
    for (int k = 0; k < PAR_W; k++) begin
      for (int pos = 1; pos < CW_W; pos++) begin
        if (((pos >> k) & 1) == 1 && !is_pow2(pos)) w_enc[1 << k] = w_enc[1 << k] ^ w_enc[pos];
      end
    end
    w_enc[0] = ^w_enc[CW_W-1:1];
  end

  // NOTE: datapath registers are reset too, because the outputs must read as zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_cw    <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1_cw <= w_enc ^ inject_mask;
    end
  end

  ecc_secded_dec #(.DATA_W(DATA_W)) u_dec (
    .i_cw            (r_s1_cw),
    .o_data          (w_dec_data),
    .o_syn           (w_dec_syn),
    .o_corrected     (w_dec_corr),
    .o_uncorrectable (w_dec_uncorr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_data   <= '0;
      r_s2_corr   <= 1'b0;
      r_s2_uncorr <= 1'b0;
      r_s2_syn    <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data   <= w_dec_data;
        r_s2_corr   <= w_dec_corr;
        r_s2_uncorr <= w_dec_uncorr;
        r_s2_syn    <= w_dec_syn;
      end
    end
  end

  // Clear takes priority over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      if (w_fire && r_s2_corr && (r_corr_cnt != '1)) r_corr_cnt <= r_corr_cnt + CNT_W'(1);
      if (w_fire && r_s2_uncorr && (r_uncorr_cnt != '1)) r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
    end
  end

  assign in_ready          = w_s1_adv;
  assign out_valid         = r_s2_valid;
  assign out_data          = r_s2_data;
  assign out_corrected     = r_s2_corr;
  assign out_uncorrectable = r_s2_uncorr;
  assign out_syndrome      = r_s2_syn;
  assign corr_cnt          = r_corr_cnt;
  assign uncorr_cnt        = r_uncorr_cnt;

endmodule

// File: tb/tb_ecc_secded_link.sv
// Self-checking bench for ecc_secded_link (DATA_W=8, CNT_W=2): directed cases,
// a backpressured stream and random traffic against a queue-based reference model.
module tb_ecc_secded_link;

  localparam int DW = 8;
  localparam int CW = 13;
  localparam int PW = 4;
  localparam int CNTW = 2;
  localparam int CNT_MAX = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] inject_mask;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_corrected;
  logic          out_uncorrectable;
  logic [PW-1:0] out_syndrome;
  logic          clr_cnt;
  logic [CNTW-1:0] corr_cnt;
  logic [CNTW-1:0] uncorr_cnt;

  ecc_secded_link #(.DATA_W(DW), .CNT_W(CNTW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .inject_mask       (inject_mask),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_corrected     (out_corrected),
    .out_uncorrectable (out_uncorrectable),
    .out_syndrome      (out_syndrome),
    .clr_cnt           (clr_cnt),
    .corr_cnt          (corr_cnt),
    .uncorr_cnt        (uncorr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [PW-1:0] syn;
    logic          corr;
    logic          unc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_corr = 0;
  int   m_unc  = 0;
  int   n_fired = 0;
  bit   last_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Encoder: place data, then choose parity bits that cancel the data-only syndrome.
  function automatic logic [CW-1:0] ref_encode(input logic [DW-1:0] d);
    logic [CW-1:0] cw;
    int n;
    int s;
    cw = '0;
    n  = 0;
    s  = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[n];
        n++;
      end
    end
    for (int pos = 1; pos < CW; pos++) if (cw[pos]) s = s ^ pos;
    for (int k = 0; k < PW; k++) cw[1 << k] = s[k];
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic exp_t ref_model(input logic [DW-1:0] d, input logic [CW-1:0] m);
    logic [CW-1:0] cw;
    exp_t r;
    int s;
    int n;
    logic pe;
    cw = ref_encode(d) ^ m;
    s = 0;
    for (int pos = 1; pos < CW; pos++) if (cw[pos]) s = s ^ pos;
    pe = ^cw;
    r.corr = 1'b0;
    r.unc  = 1'b0;
    if (s == 0) r.corr = pe;
    else if (pe && s <= CW - 1) begin
      cw[s] = ~cw[s];
      r.corr = 1'b1;
    end else r.unc = 1'b1;
    n = 0;
    r.data = '0;
    for (int pos = 1; pos < CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        r.data[n] = cw[pos];
        n++;
      end
    end
    r.syn = s[PW-1:0];
    return r;
  endfunction

  // One clock: drive, check outputs against the model, then advance model state.
  task automatic cycle(input bit iv, input logic [DW-1:0] id, input logic [CW-1:0] im,
                       input bit ordy, input bit clr);
    bit fire;
    in_valid = iv; in_data = id; inject_mask = im; out_ready = ordy; clr_cnt = clr;
    #1;
    last_acc = iv && in_ready;
    fire = out_valid && ordy;
    check("in_ready", in_ready, !(q.size() == 2 && !ordy));
    if (out_valid) begin
      if (q.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
      else begin
        check("out_data", out_data, q[0].data);
        check("out_syndrome", out_syndrome, q[0].syn);
        check("out_corrected", out_corrected, q[0].corr);
        check("out_uncorrectable", out_uncorrectable, q[0].unc);
      end
    end
    @(posedge clk);
    #1;
    if (fire && q.size() > 0) begin
      if (q[0].corr && m_corr < CNT_MAX) m_corr++;
      if (q[0].unc && m_unc < CNT_MAX) m_unc++;
      void'(q.pop_front());
      n_fired++;
    end
    if (clr) begin m_corr = 0; m_unc = 0; end
    if (last_acc) q.push_back(ref_model(id, im));
    check("corr_cnt", corr_cnt, m_corr);
    check("uncorr_cnt", uncorr_cnt, m_unc);
  endtask

  task automatic drain();
    int budget = 50;
    while (q.size() > 0 && budget > 0) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      budget--;
    end
    check("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    in_data = '0; inject_mask = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    m_corr = 0;
    m_unc  = 0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_data", out_data, '0);
    check("rst_flags", {out_corrected, out_uncorrectable}, 2'b00);
    check("rst_corr_cnt", corr_cnt, '0);
    check("rst_uncorr_cnt", uncorr_cnt, '0);
  endtask

  // Present one word with no backpressure, verify 2-cycle latency and constant expectations.
  task automatic send_directed(input string tag, input logic [DW-1:0] d, input logic [CW-1:0] m,
                               input logic [DW-1:0] exp_d, input logic [PW-1:0] exp_syn,
                               input logic exp_c, input logic exp_u,
                               input int exp_cc, input int exp_uc);
    cycle(1'b1, d, m, 1'b1, 1'b0);
    check({tag, "_lat1"}, out_valid, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check({tag, "_lat2"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_syn"}, out_syndrome, exp_syn);
    check({tag, "_corr"}, out_corrected, exp_c);
    check({tag, "_unc"}, out_uncorrectable, exp_u);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check({tag, "_corr_cnt"}, corr_cnt, exp_cc);
    check({tag, "_uncorr_cnt"}, uncorr_cnt, exp_uc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt;
    int cyc;
    logic [CW-1:0] m;
    int a;
    int b;

    do_reset();

    send_directed("clean",  8'hA5, 13'h0000, 8'hA5, 4'd0,  1'b0, 1'b0, 0, 0);
    send_directed("pos5",   8'hA5, 13'h0020, 8'hA5, 4'd5,  1'b1, 1'b0, 1, 0);
    send_directed("pos0",   8'hA5, 13'h0001, 8'hA5, 4'd0,  1'b1, 1'b0, 2, 0);
    send_directed("dbl36",  8'hA5, 13'h0048, 8'hA0, 4'd5,  1'b0, 1'b1, 2, 1);
    send_directed("syn13",  8'hA5, 13'h0112, 8'hA5, 4'd13, 1'b0, 1'b1, 2, 2);

    // Backpressured stream: out_ready toggles 1,0,1,0...
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    n_fired = 0;
    nxt = 0;
    cyc = 0;
    while (nxt < 16 && cyc < 200) begin
      cycle(1'b1, 8'(nxt), '0, (cyc % 2) == 0, 1'b0);
      if (last_acc) nxt++;
      cyc++;
    end
    check("stream_accepted", nxt, 16);
    drain();
    check("stream_emitted", n_fired, 16);

    // Random traffic with mixed error patterns and random backpressure.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: m = '0;
        1: m = CW'(1) << $urandom_range(0, CW - 1);
        2: begin
          a = $urandom_range(0, CW - 1);
          b = (a + 1 + $urandom_range(0, CW - 2)) % CW;
          m = (CW'(1) << a) | (CW'(1) << b);
        end
        default: m = CW'($urandom);
      endcase
      cycle($urandom_range(0, 3) != 0, DW'($urandom), m, $urandom_range(0, 2) != 0,
            $urandom_range(0, 63) == 0);
    end
    drain();

    // Saturation: five corrected words into a 2-bit counter.
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), CW'(1) << i, 1'b1, 1'b0);
    drain();
    check("sat_corr_cnt", corr_cnt, 2'd3);

    // Clear coincident with a corrected handshake: clear wins.
    cycle(1'b1, 8'h3C, 13'h0004, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check("clr_hs_valid", out_valid, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    check("clr_wins", corr_cnt, 2'd0);

    // Reset with two words in flight.
    send_directed("pre_rst", 8'h5A, 13'h0400, 8'h5A, 4'd10, 1'b1, 1'b0, 1, 0);
    cycle(1'b1, 8'h11, '0, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 13'h0048, 1'b0, 1'b0);
    check("inflight_valid", out_valid, 1'b1);
    check("inflight_in_ready", in_ready, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check("post_rst_no_stale", out_valid, 1'b0);
    send_directed("post_rst", 8'hC3, 13'h0000, 8'hC3, 4'd0, 1'b0, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_secded_link.md
Name: ecc_secded_link

Overview:
- Parametrised, pipelined Hamming SECDED encode → channel → decode link.
- Intended as a loopback and self-test block in the data transmission path.
- Encodes DATA_W-bit words and XORs a per-word error-injection mask onto the codeword.
- Decodes with single-error correction and double-error detection, using valid/ready handshakes and saturating error counters.

Parameters:
- DATA_W, 8: payload width, 4..64.
- PAR_W, derived localparam: smallest p with 2^p >= DATA_W+p+1 (4 for DATA_W=8).
- CW_W, derived localparam: DATA_W+PAR_W+1 (13 for DATA_W=8).
- CNT_W, 16: width of the error counters.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input word.
- in_data  in  DATA_W  payload.
- inject_mask  in  CW_W  bits to flip in the codeword; sampled with in_data.
- out_valid  out  1  decoded word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_W  corrected payload.
- out_corrected  out  1  single error corrected in this word.
- out_uncorrectable  out  1  double or undecodable error in this word.
- out_syndrome  out  PAR_W  Hamming syndrome of this word.
- clr_cnt  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of corrected words, saturating.
- uncorr_cnt  out  CNT_W  count of uncorrectable words, saturating.

Behaviour:
- Codeword layout:
  - Bit 0 is overall parity, the even parity of bits 1..CW_W-1.
  - Bits 1..CW_W-1 are Hamming positions. Parity bit k sits at position 2^k.
  - Data bits fill the non-power-of-2 positions in ascending order, in_data[0] lowest.
  - Parity bit k is the even parity of all positions whose index has bit k set.
- Stage 1 (S1): on in_valid && in_ready, register (encode(in_data) ^ inject_mask) and set s1_valid.
- Stage 2 (S2) decode:
  - syn = XOR of the indices of set bits in positions 1..CW_W-1; pe = XOR of all CW_W bits.
  - syn==0, pe==0: clean word, no flags.
  - syn==0, pe==1: overall-parity bit error. Data unchanged, out_corrected=1.
  - syn!=0, pe==1, syn<=CW_W-1: flip position syn, then extract data. out_corrected=1, even if a parity position was flipped.
  - syn!=0, pe==1, syn>CW_W-1: out_uncorrectable=1, data passed uncorrected.
  - syn!=0, pe==0: double error. out_uncorrectable=1, data passed uncorrected.
  - out_corrected and out_uncorrectable are never both 1.
- Results are registered into S2 with s2_valid. All out_* come from S2 registers.
- Latency is 2 cycles from acceptance to out_valid when there is no backpressure; throughput is 1 word per cycle.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, combinational from registered state and out_ready only; no path from in_valid.
  - While out_valid && !out_ready, S2 contents hold stable.
  - S1 holds when it cannot advance.
  - No word is ever dropped or duplicated. Pipeline depth is 2 words max.
- Counters:
  - Each increments by 1 on out_valid && out_ready && (respective flag).
  - Each saturates at 2^CNT_W-1 and holds there.
  - clr_cnt clears both to 0 next cycle; clear wins over a simultaneous increment.
- Reset (rst_n=0 at a clock edge):
  - s1_valid, s2_valid and out_valid go to 0; all out_* data and flags go to 0; both counters go to 0.
  - in_ready is 1 in the cycle after reset. Reset mid-stream discards both in-flight words.

Decomposition:
- Package ecc_secded_pkg holds:
  - function calc_par_w(data_w);
  - function is_pow2(idx);
  - functions building data↔position maps;
  - syndrome-class constants (CLEAN, CORR, UNCORR).
- One sub-module: ecc_secded_dec, purely combinational (codeword in → data, syndrome, corrected, uncorrectable), instantiated in S2.
- The encoder stays inline in S1.

Test Plan:
- DATA_W=8, in_data=0xA5, mask=0, out_ready=1 → out_data=0xA5 two cycles later; syndrome=0; no flags; counters unchanged.
- in_data=0xA5, mask=13'h0020 (position 5) → out_data=0xA5, out_corrected=1, syndrome=5, corr_cnt=1.
- mask=13'h0001 → out_data unchanged, out_corrected=1, syndrome=0. mask=13'h0048 (positions 3, 6) → out_uncorrectable=1, syndrome=5, uncorr_cnt increments.
- mask=13'h0112 (positions 1, 4, 8) → syndrome=13 > 12, out_uncorrectable=1, data not modified by the decoder.
- Stream 0x00..0x0F with out_ready toggling 1010…:
  - all 16 words emerge in order, none lost or duplicated;
  - out_data stable while stalled;
  - in_ready low only when both stages are full and out_ready=0.
- CNT_W=2, drive 5 corrected words → corr_cnt saturates at 3.
- Assert clr_cnt in the same cycle as a corrected handshake → corr_cnt=0.
- Assert rst_n=0 with 2 words in flight → out_valid=0, counters 0, and no stale word after release.
